// File: rtl/sample_period_controller_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sample_period_controller_pkg                                             |
// | Shared widths, reset value, auto-repeat timing and repeat-FSM encoding.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package sample_period_controller_pkg;

   localparam int SAMPLE_PERIOD_BITS  = 6;
   localparam int SAMPLE_PERIOD_RESET = 9;

   localparam int REPEAT_DELAY_CYCLES = 54000000;
   localparam int REPEAT_RATE_CYCLES  = 10800000;
   localparam int REPEAT_COUNTER_BITS = 26;

   localparam int                    STATE_BITS = 2;
   localparam logic [STATE_BITS-1:0] ST_IDLE    = 2'd0;
   localparam logic [STATE_BITS-1:0] ST_DELAY   = 2'd1;
   localparam logic [STATE_BITS-1:0] ST_REPEAT  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/sample_period_controller_button.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | button_auto_repeat                                                       |
// | 2-flop synchroniser plus press-and-hold repeat FSM emitting step pulses. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module button_auto_repeat #(
   parameter int REPEAT_DELAY_CYCLES = sample_period_controller_pkg::REPEAT_DELAY_CYCLES,
   parameter int REPEAT_RATE_CYCLES  = sample_period_controller_pkg::REPEAT_RATE_CYCLES,
   parameter int REPEAT_COUNTER_BITS = sample_period_controller_pkg::REPEAT_COUNTER_BITS
) (
   input  logic clock,
   input  logic reset,
   input  logic button,
   output logic step
);
   import sample_period_controller_pkg::*;

   localparam logic [REPEAT_COUNTER_BITS-1:0] DELAY_LAST =
      REPEAT_COUNTER_BITS'(REPEAT_DELAY_CYCLES - 1);
   localparam logic [REPEAT_COUNTER_BITS-1:0] RATE_LAST =
      REPEAT_COUNTER_BITS'(REPEAT_RATE_CYCLES - 1);
   localparam logic [REPEAT_COUNTER_BITS-1:0] HOLD_ONE = REPEAT_COUNTER_BITS'(1);

   logic [1:0]                     sync_q, sync_d;
   logic [STATE_BITS-1:0]          state_q, state_d;
   logic [REPEAT_COUNTER_BITS-1:0] hold_q, hold_d;
   logic                           pressed;

   assign pressed = sync_q[1];

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q  <= '0;
         state_q <= ST_IDLE;
         hold_q  <= '0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      sync_d  = {sync_q[0], button};
      state_d = state_q;
      hold_d  = hold_q;
      case (state_q)
         ST_IDLE: begin
            if (pressed) begin
               state_d = ST_DELAY;
               hold_d  = '0;
            end
         end
         ST_DELAY: begin
            if (!pressed) begin
               state_d = ST_IDLE;
            end else if (hold_q == DELAY_LAST) begin
               state_d = ST_REPEAT;
               hold_d  = '0;
            end else begin
               hold_d = hold_q + HOLD_ONE;
            end
         end
         ST_REPEAT: begin
            if (!pressed) begin
               state_d = ST_IDLE;
            end else if (hold_q == RATE_LAST) begin
               hold_d = '0;
            end else begin
               hold_d = hold_q + HOLD_ONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Mealy step: fires in the same cycle the FSM takes the matching transition.
   always_comb begin
      step = 1'b0;
      case (state_q)
         ST_IDLE:   step = pressed;
         ST_DELAY:  step = pressed && (hold_q == DELAY_LAST);
         ST_REPEAT: step = pressed && (hold_q == RATE_LAST);
         default:   step = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/sample_period_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sample_period_controller                                                 |
// | Up/Down buttons to saturating sample period; ADC tick divider strobe.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sample_period_controller #(
   parameter int SAMPLE_PERIOD_BITS  = sample_period_controller_pkg::SAMPLE_PERIOD_BITS,
   parameter int SAMPLE_PERIOD_RESET = sample_period_controller_pkg::SAMPLE_PERIOD_RESET,
   parameter int REPEAT_DELAY_CYCLES = sample_period_controller_pkg::REPEAT_DELAY_CYCLES,
   parameter int REPEAT_RATE_CYCLES  = sample_period_controller_pkg::REPEAT_RATE_CYCLES,
   parameter int REPEAT_COUNTER_BITS = sample_period_controller_pkg::REPEAT_COUNTER_BITS
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          buttonUp,
   input  logic                          buttonDown,
   input  logic                          adcTick,
   output logic [SAMPLE_PERIOD_BITS-1:0] samplePeriod,
   output logic                          sampleEnable,
   output logic                          periodChanged
);
   import sample_period_controller_pkg::*;

   localparam logic [SAMPLE_PERIOD_BITS-1:0] SP_RESET = SAMPLE_PERIOD_BITS'(SAMPLE_PERIOD_RESET);
   localparam logic [SAMPLE_PERIOD_BITS-1:0] SP_MAX   = '1;
   localparam logic [SAMPLE_PERIOD_BITS-1:0] SP_ZERO  = '0;
   localparam logic [SAMPLE_PERIOD_BITS-1:0] SP_ONE   = SAMPLE_PERIOD_BITS'(1);

   logic                          up_step, down_step;
   logic [SAMPLE_PERIOD_BITS-1:0] sample_period_q, sample_period_d;
   logic [SAMPLE_PERIOD_BITS-1:0] div_count_q, div_count_d;
   logic                          sample_enable_q, sample_enable_d;
   logic                          step_applied_q, step_applied_d;
   logic                          period_changed_q, period_changed_d;

   button_auto_repeat #(
      .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES),
      .REPEAT_COUNTER_BITS (REPEAT_COUNTER_BITS)
   ) u_repeat_up (
      .clock  (clock),
      .reset  (reset),
      .button (buttonUp),
      .step   (up_step)
   );

   button_auto_repeat #(
      .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES),
      .REPEAT_COUNTER_BITS (REPEAT_COUNTER_BITS)
   ) u_repeat_down (
      .clock  (clock),
      .reset  (reset),
      .button (buttonDown),
      .step   (down_step)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         sample_period_q  <= SP_RESET;
         div_count_q      <= '0;
         sample_enable_q  <= 1'b0;
         step_applied_q   <= 1'b0;
         period_changed_q <= 1'b0;
      end else begin
         sample_period_q  <= sample_period_d;
         div_count_q      <= div_count_d;
         sample_enable_q  <= sample_enable_d;
         step_applied_q   <= step_applied_d;
         period_changed_q <= period_changed_d;
      end
   end

   // A valid step restarts the divider and suppresses any coincident tick.
   always_comb begin
      sample_period_d  = sample_period_q;
      div_count_d      = div_count_q;
      sample_enable_d  = 1'b0;
      step_applied_d   = 1'b0;
      period_changed_d = step_applied_q;
      if (up_step && !down_step && (sample_period_q != SP_MAX)) begin
         sample_period_d = sample_period_q + SP_ONE;
         div_count_d     = '0;
         step_applied_d  = 1'b1;
      end else if (down_step && !up_step && (sample_period_q != SP_ZERO)) begin
         sample_period_d = sample_period_q - SP_ONE;
         div_count_d     = '0;
         step_applied_d  = 1'b1;
      end else if (adcTick) begin
         if (div_count_q == sample_period_q) begin
            sample_enable_d = 1'b1;
            div_count_d     = '0;
         end else begin
            div_count_d = div_count_q + SP_ONE;
         end
      end
   end

   assign samplePeriod  = sample_period_q;
   assign sampleEnable  = sample_enable_q;
   assign periodChanged = period_changed_q;

endmodule
`default_nettype wire

// File: doc/sample_period_controller.md
Name: sample_period_controller

Overview:
- Upstream of the sample-period-to-time-per-division stage.
- Converts front-panel Up/Down buttons into a saturating `samplePeriod` register, with press-and-hold auto-repeat.
- Divides the base ADC tick by (`samplePeriod`+1) to produce the capture `sampleEnable` strobe.
- Pulses `periodChanged` so the capture and display logic can clear stale traces.

Parameters:
- SAMPLE_PERIOD_BITS, 6: width of `samplePeriod`; must match the downstream time/div stage.
- SAMPLE_PERIOD_RESET, 9: `samplePeriod` value after reset (10 ticks per sample).
- REPEAT_DELAY_CYCLES, 54000000: clocks a button must be held after the first step before auto-repeat starts.
- REPEAT_RATE_CYCLES, 10800000: clocks between auto-repeat steps.
- REPEAT_COUNTER_BITS, 26: hold-counter width; must satisfy 2^bits > max(DELAY, RATE).

Ports:
- clock  in  1  system clock, single domain.
- reset  in  1  synchronous, active-high.
- buttonUp  in  1  debounced level, asynchronous to `clock`; high = pressed.
- buttonDown  in  1  debounced level, asynchronous; high = pressed.
- adcTick  in  1  one-cycle base sample-rate strobe, already in the `clock` domain.
- samplePeriod  out  SAMPLE_PERIOD_BITS  current period code; sample interval = (`samplePeriod`+1) adcTicks.
- sampleEnable  out  1  registered one-cycle capture strobe.
- periodChanged  out  1  registered one-cycle pulse, issued in the cycle after `samplePeriod` takes a new value.

Behaviour:
- **Reset (synchronous, active-high):**
  - `samplePeriod` = SAMPLE_PERIOD_RESET; `sampleEnable` = 0; `periodChanged` = 0.
  - Divider count = 0; both repeat FSMs go to IDLE; synchroniser flops = 0.
  - Reset mid-hold aborts any repeat.
  - A button still held when reset releases is seen as a fresh press and produces one step.
- **Synchroniser:** each button passes through a 2-flop synchroniser.
  - A press sampled at edge N appears in synchronised form after edge N+1.
  - The resulting step updates `samplePeriod` at edge N+2.
- **Per-button repeat FSM, states IDLE / DELAY / REPEAT:**
  - IDLE: synchronised button high → emit step, clear hold counter, go to DELAY.
  - DELAY: button low → IDLE. Hold counter reaches REPEAT_DELAY_CYCLES-1 → emit step, clear counter, go to REPEAT. Otherwise counter +1.
  - REPEAT: button low → IDLE. Counter reaches REPEAT_RATE_CYCLES-1 → emit step, clear counter. Otherwise counter +1.
- **Step resolution (one clock):**
  - Up step and down step in the same cycle → no change, no `periodChanged`; both FSMs keep advancing independently.
  - Up step at `samplePeriod` = 2^SAMPLE_PERIOD_BITS-1 → ignored: saturate, no wrap, no pulse.
  - Down step at 0 → ignored.
  - Valid step → `samplePeriod` ±1, divider count ← 0, `periodChanged` = 1 on the next cycle.
- **Divider:**
  - `adcTick` && count == `samplePeriod` → `sampleEnable` = 1 next cycle, count ← 0.
  - `adcTick` alone → count +1.
  - With `samplePeriod` = 0, every `adcTick` produces a strobe one cycle later.
  - Valid step coinciding with `adcTick` → the step wins: count ← 0 and no strobe is produced for that tick.
- **Arithmetic:** count is SAMPLE_PERIOD_BITS wide and is compared for equality only; no overflow is possible.

Decomposition:
- Shared package holds:
  - SAMPLE_PERIOD_BITS and SAMPLE_PERIOD_RESET, shared with the time/div stage and the display text block.
  - Repeat timing constants.
  - FSM state encoding: IDLE=0, DELAY=1, REPEAT=2.
- One sub-module, `button_auto_repeat`, containing the synchroniser, FSM and hold counter, with output `step` (1-cycle pulse). It is instantiated twice.
- The top level contains step resolution, the saturating register and the divider.

Test Plan:
- Bench overrides: DELAY=20, RATE=5.
- Reset, then 25 `adcTick` pulses spaced 3 clocks apart → `samplePeriod`=9; `sampleEnable` follows ticks #10 and #20 by one clock; no `periodChanged`.
- `buttonUp` high for 1 clock at edge N → `samplePeriod`=10 after edge N+2; `periodChanged` high exactly one cycle, at N+3; next strobe after 11 ticks.
- `buttonUp` held 40 clocks → steps at offsets 0, 20, 25, 30, 35 → `samplePeriod` 9→14; release → no further steps.
- Set `samplePeriod`=63, press Up → stays 63, no pulse. Set it to 0, press Down → stays 0. With `samplePeriod`=0, every `adcTick` produces a `sampleEnable`.
- Up and Down asserted in the same clock → value unchanged, no `periodChanged`. Step coinciding with `adcTick` at count == `samplePeriod` → no `sampleEnable`, count restarts from 0.
- Assert reset while `buttonUp` is held in REPEAT → `samplePeriod`=9 immediately. After release of reset with the button still held → exactly one step to 10, then repeat resumes after 20 clocks.
